// File: rtl/pb_event_decoder.sv
// -----------------------------------------------------------------------------
// pb_event_decoder
//
// Turns the debounced push-button signal into single-cycle press events. It
// classifies each press as a single or a double press using a programmable
// window, and keeps a wrapping count of presses.
//
// Parameters:
//   WINDOW_CYCLES  double-press window length in clk cycles (2 .. 2^TIMER_W-1)
//   TIMER_W        window timer width
//   CNT_W          press counter width
//
// Ports:
//   clk           in   system clock (100 MHz), single clock domain
//   rst_n         in   asynchronous active-low reset
//   pb_pulse      in   debounced button level, synchronous to clk
//   press_evt     out  one-cycle pulse per rising edge of pb_pulse
//   single_press  out  one-cycle pulse, press with no second press in window
//   double_press  out  one-cycle pulse, second press arrived inside window
//   press_count   out  presses since reset, wrapping at 2^CNT_W
//   busy          out  high while a classification window is open
//
// Every output is driven straight from a flop. busy is the one-bit state
// register itself.
// -----------------------------------------------------------------------------
module pb_event_decoder #(
  parameter int unsigned WINDOW_CYCLES = 50000000,
  parameter int unsigned TIMER_W       = 26,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pb_pulse,
  output logic             press_evt,
  output logic             single_press,
  output logic             double_press,
  output logic [CNT_W-1:0] press_count,
  output logic             busy
);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam logic [TIMER_W-1:0] WIN_LAST = TIMER_W'(WINDOW_CYCLES - 1);

  function automatic logic [CNT_W-1:0] cnt_wrap_inc(input logic [CNT_W-1:0] v);
    return v + CNT_W'(1);
  endfunction

  function automatic logic [TIMER_W-1:0] timer_inc(input logic [TIMER_W-1:0] v);
    return v + TIMER_W'(1);
  endfunction

  logic               pb_d;
  logic               edge_p0;
  state_t             state_q;
  state_t             state_d;
  logic [TIMER_W-1:0] timer_q;
  logic [TIMER_W-1:0] timer_d;
  logic               single_d;
  logic               double_d;

  // Stage p0: edge detection. pb_d comes out of reset high, so a level that
  // is already high when reset is released does not count as a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pb_d <= 1'b1;
    end else begin
      pb_d <= pb_pulse;
    end
  end

  assign edge_p0 = pb_pulse & ~pb_d;

  // Stage p0 -> p1: classification FSM. Inside a window an edge is checked
  // before the timeout, so an edge that lands on the last window cycle is a
  // double. The closing edge returns to IDLE and never opens a new window.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    single_d = 1'b0;
    double_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (edge_p0) begin
          state_d = WAIT;
          timer_d = '0;
        end
      end
      WAIT: begin
        if (edge_p0) begin
          double_d = 1'b1;
          state_d  = IDLE;
        end else if (timer_q == WIN_LAST) begin
          single_d = 1'b1;
          state_d  = IDLE;
        end else begin
          timer_d = timer_inc(timer_q);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  // Stage p1: registered event outputs and press counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      press_evt    <= 1'b0;
      single_press <= 1'b0;
      double_press <= 1'b0;
      press_count  <= '0;
    end else begin
      press_evt    <= edge_p0;
      single_press <= single_d;
      double_press <= double_d;
      if (edge_p0) begin
        press_count <= cnt_wrap_inc(press_count);
      end
    end
  end

  assign busy = (state_q == WAIT);

endmodule

// File: doc/pb_event_decoder.md
# pb_event_decoder

Downstream consumer of the debounced push-button pulse. Converts the debounced level/pulse into single-cycle press events, classifies each press as a single or a double press using a programmable time window, and keeps a wrapping press counter. It sits between the button debouncer and the application logic, such as mode selection or seven-segment display control, in the 100 MHz clock domain.

## Interface
- WINDOW_CYCLES, 50000000: double-press window length in clk cycles (0.5 s at 100 MHz); legal range 2..2^TIMER_W-1.
- TIMER_W, 26: window timer width.
- CNT_W, 8: press counter width.

Ports:
- clk  in  1  system clock, 100 MHz, single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- pb_pulse  in  1  debounced button signal, synchronous to clk; may stay high for any number of cycles.
- press_evt  out  1  one-cycle pulse per detected press (every rising edge of pb_pulse).
- single_press  out  1  one-cycle pulse: press not followed by a second press within the window.
- double_press  out  1  one-cycle pulse: two presses within the window.
- press_count  out  CNT_W  total presses since reset, wrapping.
- busy  out  1  high while a window is open (state WAIT).

## Operation
- Edge detect:
  - pb_d registers pb_pulse each cycle; pb_d resets to 1.
  - edge = pb_pulse & ~pb_d. A level already high when reset is released produces no edge.
  - pb_pulse must fall and rise again before another edge is seen, so edges are at least 2 cycles apart.
- press_evt: registered copy of edge.
- press_count: increments by 1 on every edge. Wraps from 2^CNT_W-1 to 0. No saturation.
- FSM with two states, IDLE and WAIT; reset state IDLE.
  - IDLE: on edge, go to WAIT with timer <= 0.
  - WAIT, evaluated in priority order each cycle:
    - edge: assert double_press next cycle, go to IDLE.
    - else if timer == WINDOW_CYCLES-1: assert single_press next cycle, go to IDLE.
    - else: timer <= timer+1.
  - Edge coincident with the timeout cycle counts as double; the edge wins.
  - The press that closes a double is never reused to open a new window.
  - An edge in the first IDLE cycle after a decision opens a new window normally.
- busy = (state == WAIT). This is the registered state; no combinational path from pb_pulse.
- Mutual exclusion: single_press and double_press are never high in the same cycle.
- Reset mid-operation:
  - rst_n low immediately forces IDLE, timer 0, count 0, and all pulse outputs 0.
  - Any pending classification is discarded; no pulse is emitted.

## Timing
- Reset values:
  - press_evt, single_press, double_press, busy: 0.
  - press_count: 0.
  - Internal: pb_d 1, timer 0.
- Let the first edge occur in cycle 0 (pb_pulse high, pb_d low).
  - Cycle 1: press_evt = 1, press_count updated, busy = 1.
  - A second edge in any cycle k, 1 <= k <= WINDOW_CYCLES, gives double_press = 1 in cycle k+1 and busy = 0 in cycle k+1.
  - With no second edge, single_press = 1 in cycle WINDOW_CYCLES+1 and busy = 0 in that cycle.
- Every pulse output is exactly 1 cycle wide.
- All outputs come directly from flops.
- Latency from edge to press_evt: 1 cycle.

## Test plan
All scenarios use WINDOW_CYCLES=8 and CNT_W=4.
- Reset mid-window: assert rst_n low at cycle 3 of a window. Required: all outputs 0 immediately. After release, no single_press; press_count = 0.
- Held input: hold pb_pulse high through reset release for 20 cycles. Required: no press_evt, count stays 0. Then one low-high toggle gives exactly one press_evt.
- Single press: pb_pulse high cycles 0-2, then low. Required: press_evt at cycle 1; busy cycles 1-8; single_press at cycle 9 only; press_count = 1.
- Double press: edges at cycle 0 and cycle 4. Required: press_evt at cycles 1 and 5; double_press at cycle 5; no single_press; press_count = 2.
- Window boundaries:
  - Second edge exactly at cycle 8: double_press at cycle 9, no single_press.
  - Second edge at cycle 9: single_press at cycle 9, then a new window opened by that edge.
- Counter wrap and back-to-back: 17 presses at 3-cycle spacing. Required: press_count reads 1 (wrap through 0); double_press pulses for pairs (1,2), (3,4), and so on; the 17th press gives single_press.
